// File: rtl/usr_pkg.sv
// usr_pkg -- command and state encodings for universal_shift_register (rev 1.0)
`default_nettype none

package usr_pkg;

  typedef enum logic [2:0] {
    MODE_LOAD = 3'd0,
    MODE_SHL  = 3'd1,
    MODE_SHR  = 3'd2,
    MODE_ROL  = 3'd3,
    MODE_ROR  = 3'd4,
    MODE_ASR  = 3'd5
  } mode_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } usr_state_t;

  // Encodings 6 and 7 are reserved and behave as no-ops.
  function automatic logic is_shift_mode(input logic [2:0] m);
    return (m >= 3'(MODE_SHL)) && (m <= 3'(MODE_ASR));
  endfunction

endpackage

`default_nettype wire

// File: rtl/usr_step.sv
// usr_step -- combinational single-bit shift/rotate step (rev 1.0)
`default_nettype none

module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  mode_t            mode,
  input  logic             serial_in_lsb,
  input  logic             serial_in_msb,
  output logic [WIDTH-1:0] q_next,
  output logic             bit_out
);

  always_comb begin
    q_next  = q;
    bit_out = 1'b0;
    case (mode)
      MODE_SHL: begin
        q_next  = {q[WIDTH-2:0], serial_in_lsb};
        bit_out = q[WIDTH-1];
      end
      MODE_SHR: begin
        q_next  = {serial_in_msb, q[WIDTH-1:1]};
        bit_out = q[0];
      end
      MODE_ROL: begin
        q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
        bit_out = q[WIDTH-1];
      end
      MODE_ROR: begin
        q_next  = {q[0], q[WIDTH-1:1]};
        bit_out = q[0];
      end
      MODE_ASR: begin
        q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
        bit_out = q[0];
      end
      default: begin
        q_next  = q;
        bit_out = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/universal_shift_register.sv
// universal_shift_register -- load / multi-step shift / rotate with start-busy-done handshake (rev 1.0)
`default_nettype none

module universal_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] shift_count,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             serial_in_lsb,
  input  logic             serial_in_msb,
  output logic [WIDTH-1:0] parallel_out,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  usr_state_t       r_state;
  mode_t            r_mode;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_q;
  logic             r_sout;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_q_next;
  logic             w_bit_out;
  logic             w_last_step;

  usr_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .q             (r_q),
    .mode          (r_mode),
    .serial_in_lsb (serial_in_lsb),
    .serial_in_msb (serial_in_msb),
    .q_next        (w_q_next),
    .bit_out       (w_bit_out)
  );

  assign w_last_step = (r_cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_LOAD;
      r_cnt   <= '0;
      r_q     <= '0;
      r_sout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (mode == 3'(MODE_LOAD)) begin
              r_q    <= parallel_in;
              r_done <= 1'b1;
            end else if (is_shift_mode(mode) && (shift_count != '0)) begin
              r_mode  <= mode_t'(mode);
              r_cnt   <= shift_count;
              r_busy  <= 1'b1;
              r_state <= ST_SHIFT;
            end else begin
              // Zero count or reserved mode: acknowledge without touching data.
              r_done <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          r_q    <= w_q_next;
          r_sout <= w_bit_out;
          r_cnt  <= r_cnt - CNT_W'(1);
          if (w_last_step) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign parallel_out = r_q;
  assign serial_out   = r_sout;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

`default_nettype wire

// File: tb/tb_universal_shift_register.sv
// tb_universal_shift_register -- directed self-checking bench (rev 1.0)
`default_nettype none

module tb_universal_shift_register;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    mode;
  logic [CW-1:0] shift_count;
  logic [W-1:0]  parallel_in;
  logic          serial_in_lsb;
  logic          serial_in_msb;
  logic [W-1:0]  parallel_out;
  logic          serial_out;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  universal_shift_register #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .mode          (mode),
    .shift_count   (shift_count),
    .parallel_in   (parallel_in),
    .serial_in_lsb (serial_in_lsb),
    .serial_in_msb (serial_in_msb),
    .parallel_out  (parallel_out),
    .serial_out    (serial_out),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; mode = 3'd0; parallel_in = 8'hFF;
    tick(); tick();
    reset = 1'b0; start = 1'b0;
    checks++; if (parallel_out !== 8'h00) begin errors++; $display("FAIL reset_q: got %h expected 00", parallel_out); end
    checks++; if (serial_out !== 1'b0) begin errors++; $display("FAIL reset_sout: got %b expected 0", serial_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
  endtask

  task automatic do_load(input logic [W-1:0] d);
    start = 1'b1; mode = 3'd0; parallel_in = d;
    tick();
    start = 1'b0;
    checks++; if (parallel_out !== d) begin errors++; $display("FAIL load_q: got %h expected %h", parallel_out, d); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL load_done: got %b expected 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL load_busy: got %b expected 0", busy); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL load_done_clear: got %b expected 0", done); end
  endtask

  task automatic run_shift(input logic [2:0] m, input int n, input logic [W-1:0] exp_q, input logic exp_s);
    start = 1'b1; mode = m; shift_count = CW'(n);
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL shift_accept m=%0d n=%0d: busy=%b done=%b expected busy=1 done=0", m, n, busy, done); end
    for (int i = 1; i < n; i++) begin
      tick();
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL shift_busy m=%0d step=%0d: busy=%b done=%b expected 1/0", m, i, busy, done); end
    end
    tick();
    checks++; if (parallel_out !== exp_q) begin errors++; $display("FAIL shift_q m=%0d n=%0d: got %h expected %h", m, n, parallel_out, exp_q); end
    checks++; if (serial_out !== exp_s) begin errors++; $display("FAIL shift_sout m=%0d n=%0d: got %b expected %b", m, n, serial_out, exp_s); end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL shift_done m=%0d n=%0d: done=%b busy=%b expected 1/0", m, n, done, busy); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL shift_done_clear m=%0d: got %b expected 0", m, done); end
  endtask

  task automatic test_load();
    do_load(8'hAD);
  endtask

  task automatic test_shl();
    logic [W-1:0] exp_q [3];
    logic         exp_s [3];
    exp_q[0] = 8'h5B; exp_q[1] = 8'hB7; exp_q[2] = 8'h6F;
    exp_s[0] = 1'b1;  exp_s[1] = 1'b0;  exp_s[2] = 1'b1;
    serial_in_lsb = 1'b1;
    start = 1'b1; mode = 3'd1; shift_count = CW'(3);
    tick();
    start = 1'b0;
    checks++; if (parallel_out !== 8'hAD || busy !== 1'b1) begin errors++; $display("FAIL shl_accept: q=%h busy=%b expected AD/1", parallel_out, busy); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (parallel_out !== exp_q[i]) begin errors++; $display("FAIL shl_step%0d_q: got %h expected %h", i, parallel_out, exp_q[i]); end
      checks++; if (serial_out !== exp_s[i]) begin errors++; $display("FAIL shl_step%0d_sout: got %b expected %b", i, serial_out, exp_s[i]); end
      checks++; if (busy !== (i < 2) || done !== (i == 2)) begin errors++; $display("FAIL shl_step%0d_hs: busy=%b done=%b", i, busy, done); end
    end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL shl_done_clear: got %b expected 0", done); end
    serial_in_lsb = 1'b0;
  endtask

  task automatic test_rotate();
    do_load(8'hF0);
    run_shift(3'd4, 4, 8'h0F, 1'b0);
    run_shift(3'd3, 8, 8'h0F, 1'b1);
    run_shift(3'd3, 12, 8'hF0, 1'b0);
  endtask

  task automatic test_arith_logical_right();
    do_load(8'h90);
    run_shift(3'd5, 2, 8'hE4, 1'b0);
    serial_in_msb = 1'b0;
    run_shift(3'd2, 1, 8'h72, 1'b0);
    serial_in_msb = 1'b1;
    run_shift(3'd2, 2, 8'hDC, 1'b1);
    serial_in_msb = 1'b0;
  endtask

  task automatic test_noop();
    logic [2:0] modes [3];
    int         cnts  [3];
    modes[0] = 3'd1; cnts[0] = 0;
    modes[1] = 3'd6; cnts[1] = 3;
    modes[2] = 3'd7; cnts[2] = 2;
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; mode = modes[i]; shift_count = CW'(cnts[i]); parallel_in = 8'h00;
      tick();
      start = 1'b0;
      checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL noop%0d_hs: done=%b busy=%b expected 1/0", i, done, busy); end
      checks++; if (parallel_out !== 8'hDC || serial_out !== 1'b1) begin errors++; $display("FAIL noop%0d_data: q=%h sout=%b expected DC/1", i, parallel_out, serial_out); end
      tick();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL noop%0d_idle: done=%b busy=%b expected 0/0", i, done, busy); end
    end
  endtask

  task automatic test_start_while_busy();
    start = 1'b1; mode = 3'd3; shift_count = CW'(3);
    tick();
    mode = 3'd0; parallel_in = 8'h00;
    tick();
    checks++; if (parallel_out !== 8'hB9 || busy !== 1'b1) begin errors++; $display("FAIL swb_step1: q=%h busy=%b expected B9/1", parallel_out, busy); end
    tick();
    checks++; if (parallel_out !== 8'h73 || busy !== 1'b1) begin errors++; $display("FAIL swb_step2: q=%h busy=%b expected 73/1", parallel_out, busy); end
    tick();
    start = 1'b0;
    checks++; if (parallel_out !== 8'hE6 || serial_out !== 1'b0) begin errors++; $display("FAIL swb_result: q=%h sout=%b expected E6/0", parallel_out, serial_out); end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL swb_done: done=%b busy=%b expected 1/0", done, busy); end
    tick();
    checks++; if (done !== 1'b0 || parallel_out !== 8'hE6) begin errors++; $display("FAIL swb_after: done=%b q=%h expected 0/E6", done, parallel_out); end
  endtask

  task automatic test_back_to_back();
    serial_in_lsb = 1'b0;
    start = 1'b1; mode = 3'd1; shift_count = CW'(1);
    tick();
    mode = 3'd0; parallel_in = 8'h55;
    tick();
    checks++; if (parallel_out !== 8'hCC || serial_out !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL b2b_shift: q=%h sout=%b done=%b expected CC/1/1", parallel_out, serial_out, done); end
    tick();
    parallel_in = 8'h0F;
    checks++; if (parallel_out !== 8'h55 || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_load1: q=%h done=%b busy=%b expected 55/1/0", parallel_out, done, busy); end
    tick();
    start = 1'b0;
    checks++; if (parallel_out !== 8'h0F || done !== 1'b1) begin errors++; $display("FAIL b2b_load2: q=%h done=%b expected 0F/1", parallel_out, done); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_clear: got %b expected 0", done); end
  endtask

  task automatic test_reset_mid();
    do_load(8'hFF);
    serial_in_lsb = 1'b0;
    start = 1'b1; mode = 3'd1; shift_count = CW'(5);
    tick();
    start = 1'b0;
    tick(); tick();
    checks++; if (parallel_out !== 8'hFC || serial_out !== 1'b1) begin errors++; $display("FAIL rmid_pre: q=%h sout=%b expected FC/1", parallel_out, serial_out); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (parallel_out !== 8'h00 || serial_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rmid_reset: q=%h sout=%b busy=%b done=%b expected 00/0/0/0", parallel_out, serial_out, busy, done); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (done !== 1'b0 || busy !== 1'b0 || parallel_out !== 8'h00) begin errors++; $display("FAIL rmid_quiet%0d: done=%b busy=%b q=%h expected 0/0/00", i, done, busy, parallel_out); end
    end
    do_load(8'h3C);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 3'd0; shift_count = '0;
    parallel_in = '0; serial_in_lsb = 1'b0; serial_in_msb = 1'b0;
    test_reset();
    test_load();
    test_shl();
    test_rotate();
    test_arith_logical_right();
    test_noop();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
